// File: rtl/kc705_ethernet_cmd_reg_map_pkg.sv
// Shared definitions for the Ethernet command register map: default geometry,
// command codes, packet length helper and FSM state encoding.
package kc705_ethernet_cmd_reg_map_pkg;

  localparam int DEF_REG_WIDTH     = 4;
  localparam int DEF_NUM_REG       = 6;
  localparam int DEF_CMD_LENGTH    = 4;
  localparam int DEF_PKT_ID_LENGTH = 4;
  localparam int DEF_CNT_WIDTH     = 16;

  // "WREG" in ASCII, the only command that commits a register image
  localparam logic [31:0] CMD_WRITE_CODE = 32'h5752_4547;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic int calc_len(input int cmd_len, input int id_len,
                                  input int reg_width, input int num_reg);
    return cmd_len + id_len + reg_width * num_reg;
  endfunction

endpackage

// File: rtl/kc705_ethernet_cmd_reg_map_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module kc705_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/kc705_ethernet_cmd_reg_map.sv
// Assembles a big-endian command packet from the Ethernet RX byte stream and
// presents the validated register image on a valid/ready bus.
//
//   state     | meaning
//   ST_RECV   | accepting bytes 0..LEN-1 into the shadow register
//   ST_DRAIN  | packet overran LEN; discard bytes until tlast
//   ST_COMMIT | image held on reg_map_*, waiting for reg_map_ready
module kc705_ethernet_cmd_reg_map
  import kc705_ethernet_cmd_reg_map_pkg::*;
#(
  parameter int                      REG_WIDTH     = DEF_REG_WIDTH,
  parameter int                      NUM_REG       = DEF_NUM_REG,
  parameter int                      CMD_LENGTH    = DEF_CMD_LENGTH,
  parameter int                      PKT_ID_LENGTH = DEF_PKT_ID_LENGTH,
  parameter logic [8*CMD_LENGTH-1:0] CMD_WRITE     = (8*CMD_LENGTH)'(CMD_WRITE_CODE),
  parameter int                      CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                              axi_tclk,
  input  logic                              axi_treset,
  input  logic [7:0]                        rx_tdata,
  input  logic                              rx_tvalid,
  input  logic                              rx_tlast,
  output logic                              rx_tready,
  output logic [8*REG_WIDTH*NUM_REG-1:0]    reg_map_data,
  output logic [8*CMD_LENGTH-1:0]           reg_map_cmd,
  output logic [8*PKT_ID_LENGTH-1:0]        reg_map_pkt_id,
  output logic                              reg_map_valid,
  input  logic                              reg_map_ready,
  output logic [CNT_WIDTH-1:0]              pkt_ok_count,
  output logic [CNT_WIDTH-1:0]              pkt_err_count,
  output logic                              pkt_err
);

  localparam int LEN    = calc_len(CMD_LENGTH, PKT_ID_LENGTH, REG_WIDTH, NUM_REG);
  localparam int CMD_W  = 8 * CMD_LENGTH;
  localparam int ID_W   = 8 * PKT_ID_LENGTH;
  localparam int DATA_W = 8 * REG_WIDTH * NUM_REG;
  localparam int SH_W   = 8 * LEN;
  localparam int IDX_W  = $clog2(LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  // The final byte never needs storing: it is taken straight from rx_tdata.
  logic [SH_W-9:0]     shadow_q, shadow_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                pkt_err_q;
  logic                err_evt;
  logic                ok_evt;
  logic                beat;
  logic [SH_W-1:0]     shift_next;

  assign rx_tready  = !axi_treset && (state_q != ST_COMMIT);
  assign beat       = rx_tvalid && rx_tready;
  assign shift_next = {shadow_q, rx_tdata};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cmd_d    = cmd_q;
    id_d     = id_q;
    err_evt  = 1'b0;
    ok_evt   = 1'b0;

    case (state_q)
      ST_RECV: begin
        if (beat) begin
          shadow_d = shift_next[SH_W-9:0];
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!rx_tlast) begin
              state_d = ST_DRAIN;
            end else if (shift_next[DATA_W+ID_W +: CMD_W] == CMD_WRITE) begin
              state_d = ST_COMMIT;
              data_d  = shift_next[DATA_W-1:0];
              id_d    = shift_next[DATA_W +: ID_W];
              cmd_d   = shift_next[DATA_W+ID_W +: CMD_W];
            end else begin
              err_evt = 1'b1;
            end
          end else if (rx_tlast) begin
            idx_d   = '0;
            err_evt = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (beat && rx_tlast) begin
          state_d = ST_RECV;
          err_evt = 1'b1;
        end
      end
      ST_COMMIT: begin
        if (reg_map_ready) begin
          state_d = ST_RECV;
          ok_evt  = 1'b1;
        end
      end
      default: begin
        state_d = ST_RECV;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      state_q   <= ST_RECV;
      idx_q     <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      cmd_q     <= '0;
      id_q      <= '0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      cmd_q     <= cmd_d;
      id_q      <= id_d;
      pkt_err_q <= err_evt;
    end
  end

  // pkt_err and the error count both become visible on the edge after the bad beat.
  kc705_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ok_cnt (
    .clk   (axi_tclk),
    .clear (axi_treset),
    .inc   (ok_evt),
    .count (pkt_ok_count)
  );

  kc705_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (axi_tclk),
    .clear (axi_treset),
    .inc   (err_evt),
    .count (pkt_err_count)
  );

  assign reg_map_data   = data_q;
  assign reg_map_cmd    = cmd_q;
  assign reg_map_pkt_id = id_q;
  assign reg_map_valid  = (state_q == ST_COMMIT);
  assign pkt_err        = pkt_err_q;

endmodule

// File: tb/tb_kc705_ethernet_cmd_reg_map.sv
// Bench for kc705_ethernet_cmd_reg_map: directed scenarios plus randomized packets
// against a packet-level reference model; a 2-bit-counter twin checks saturation.
module tb_kc705_ethernet_cmd_reg_map;

  localparam int          LEN  = 32;
  localparam logic [31:0] WREG = 32'h5752_4547;

  typedef logic [7:0] bq_t[$];

  logic         clk;
  logic         rst;
  logic [7:0]   rx_tdata;
  logic         rx_tvalid;
  logic         rx_tlast;
  logic         rx_tready;
  logic [191:0] reg_map_data;
  logic [31:0]  reg_map_cmd;
  logic [31:0]  reg_map_pkt_id;
  logic         reg_map_valid;
  logic         reg_map_ready;
  logic [15:0]  ok_cnt;
  logic [15:0]  err_cnt;
  logic         pkt_err;

  logic         rx_tready2;
  logic [191:0] data2;
  logic [31:0]  cmd2;
  logic [31:0]  id2;
  logic         valid2;
  logic [1:0]   ok_cnt2;
  logic [1:0]   err_cnt2;
  logic         pkt_err2;

  int total;
  int bad;
  int exp_ok;
  int exp_err;
  logic [191:0] exp_data;
  logic [31:0]  exp_cmd;
  logic [31:0]  exp_id;
  int valid_cycles;

  kc705_ethernet_cmd_reg_map dut (
    .axi_tclk(clk), .axi_treset(rst),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
    .reg_map_data(reg_map_data), .reg_map_cmd(reg_map_cmd), .reg_map_pkt_id(reg_map_pkt_id),
    .reg_map_valid(reg_map_valid), .reg_map_ready(reg_map_ready),
    .pkt_ok_count(ok_cnt), .pkt_err_count(err_cnt), .pkt_err(pkt_err)
  );

  kc705_ethernet_cmd_reg_map #(.CNT_WIDTH(2)) dut_sat (
    .axi_tclk(clk), .axi_treset(rst),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready2),
    .reg_map_data(data2), .reg_map_cmd(cmd2), .reg_map_pkt_id(id2),
    .reg_map_valid(valid2), .reg_map_ready(reg_map_ready),
    .pkt_ok_count(ok_cnt2), .pkt_err_count(err_cnt2), .pkt_err(pkt_err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial valid_cycles = 0;
  always @(negedge clk) if (reg_map_valid) valid_cycles <= valid_cycles + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic logic [191:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bq_t make_pkt(input logic [31:0] cmd, input logic [31:0] id,
                                   input logic [191:0] data);
    bq_t p;
    p = {};
    for (int i = 3; i >= 0; i--) p.push_back(cmd[8*i +: 8]);
    for (int i = 3; i >= 0; i--) p.push_back(id[8*i +: 8]);
    for (int i = 23; i >= 0; i--) p.push_back(data[8*i +: 8]);
    return p;
  endfunction

  function automatic bit is_good(input bq_t p);
    if (p.size() != LEN) return 1'b0;
    return {p[0], p[1], p[2], p[3]} == WREG;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a packet, honouring rx_tready; returns once the last byte is accepted.
  task automatic send_pkt(input bq_t p, input bit gaps, input bit with_last, output bit timeout);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    timeout = 1'b0;
    while (i < p.size()) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        rx_tvalid = 1'b0;
        rx_tdata  = 8'($urandom);
        rx_tlast  = 1'($urandom);
      end else begin
        rx_tvalid = 1'b1;
        rx_tdata  = p[i];
        rx_tlast  = with_last && (i == p.size() - 1);
      end
      #1;
      acc = rx_tvalid && rx_tready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (guard > 1000) begin
        timeout = 1'b1;
        break;
      end
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = 8'h00; reg_map_ready = 1'b1;
    repeat (3) step();
    total++;
    if (rx_tready !== 1'b0) begin bad++; $display("FAIL reset_tready_low got=%b want=0", rx_tready); end
    rst = 1'b0;
    #1;
    exp_ok = 0; exp_err = 0; exp_data = '0; exp_cmd = '0; exp_id = '0;
    total++;
    if (rx_tready !== 1'b1) begin bad++; $display("FAIL reset_tready_high got=%b want=1", rx_tready); end
    total++;
    if (reg_map_valid !== 1'b0 || pkt_err !== 1'b0) begin
      bad++; $display("FAIL reset_valid_err got=%b/%b want=0/0", reg_map_valid, pkt_err);
    end
    total++;
    if (reg_map_data !== 192'd0 || reg_map_cmd !== 32'd0 || reg_map_pkt_id !== 32'd0) begin
      bad++; $display("FAIL reset_image got=%h/%h/%h want=0", reg_map_data, reg_map_cmd, reg_map_pkt_id);
    end
    total++;
    if (ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_basic();
    bq_t p;
    bit to;
    logic [191:0] d;
    d = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    p = make_pkt(WREG, 32'd7, d);
    reg_map_ready = 1'b1;
    send_pkt(p, 1'b0, 1'b1, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=timeout want=done"); end
    total++;
    if (reg_map_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", reg_map_valid); end
    total++;
    if (reg_map_data[191:160] !== 32'd1 || reg_map_data[31:0] !== 32'd6) begin
      bad++; $display("FAIL basic_reg0_reg5 got=%h/%h want=1/6", reg_map_data[191:160], reg_map_data[31:0]);
    end
    total++;
    if (reg_map_pkt_id !== 32'd7 || reg_map_cmd !== WREG) begin
      bad++; $display("FAIL basic_id_cmd got=%h/%h want=7/%h", reg_map_pkt_id, reg_map_cmd, WREG);
    end
    step();
    exp_ok++; exp_data = d; exp_cmd = WREG; exp_id = 32'd7;
    total++;
    if (reg_map_valid !== 1'b0 || ok_cnt !== 16'(exp_ok)) begin
      bad++; $display("FAIL basic_handshake got=valid%b ok%0d want=valid0 ok%0d", reg_map_valid, ok_cnt, exp_ok);
    end
    total++;
    if (reg_map_data !== exp_data) begin
      bad++; $display("FAIL basic_hold_after got=%h want=%h", reg_map_data, exp_data);
    end
  endtask

  task automatic test_backpressure();
    bq_t p;
    bit to;
    logic [191:0] d;
    logic [31:0] id;
    int hold_bad;
    d = rand192(); id = $urandom;
    p = make_pkt(WREG, id, d);
    reg_map_ready = 1'b0;
    send_pkt(p, 1'b1, 1'b1, to);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got=timeout want=done"); end
    rx_tvalid = 1'b1; rx_tdata = 8'hAA; rx_tlast = 1'b1;
    hold_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (reg_map_valid !== 1'b1 || rx_tready !== 1'b0 || reg_map_data !== d || reg_map_pkt_id !== id)
        hold_bad++;
      step();
    end
    total++;
    if (hold_bad != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", hold_bad); end
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
    reg_map_ready = 1'b1;
    step();
    exp_ok++; exp_data = d; exp_id = id; exp_cmd = WREG;
    total++;
    if (reg_map_valid !== 1'b0 || ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
      bad++; $display("FAIL bp_release got=valid%b ok%0d err%0d want=valid0 ok%0d err%0d",
                      reg_map_valid, ok_cnt, err_cnt, exp_ok, exp_err);
    end
    d = rand192(); id = $urandom;
    p = make_pkt(WREG, id, d);
    send_pkt(p, 1'b1, 1'b1, to);
    total++;
    if (to || reg_map_valid !== 1'b1 || reg_map_data !== d || reg_map_pkt_id !== id) begin
      bad++; $display("FAIL bp_second got=%b %h %h want=1 %h %h", reg_map_valid, reg_map_data, reg_map_pkt_id, d, id);
    end
    step();
    exp_ok++; exp_data = d; exp_id = id;
  endtask

  task automatic test_short();
    bq_t p;
    bit to;
    logic [191:0] d;
    int vc0;
    p = make_pkt(WREG, $urandom, rand192());
    while (p.size() > 20) void'(p.pop_back());
    vc0 = valid_cycles;
    send_pkt(p, 1'b1, 1'b1, to);
    exp_err++;
    total++;
    if (to || pkt_err !== 1'b1 || err_cnt !== 16'(exp_err)) begin
      bad++; $display("FAIL short_err got=pulse%b err%0d want=pulse1 err%0d", pkt_err, err_cnt, exp_err);
    end
    step();
    total++;
    if (pkt_err !== 1'b0 || valid_cycles != vc0) begin
      bad++; $display("FAIL short_after got=pulse%b valid_cycles%0d want=pulse0 valid_cycles%0d",
                      pkt_err, valid_cycles, vc0);
    end
    d = rand192();
    p = make_pkt(WREG, 32'h0000_00C3, d);
    send_pkt(p, 1'b0, 1'b1, to);
    total++;
    if (to || reg_map_valid !== 1'b1 || reg_map_data !== d || reg_map_pkt_id !== 32'h0000_00C3) begin
      bad++; $display("FAIL short_recover got=%b %h want=1 %h", reg_map_valid, reg_map_data, d);
    end
    step();
    exp_ok++; exp_data = d; exp_id = 32'h0000_00C3;
  endtask

  task automatic test_long();
    bq_t p;
    bit to;
    int vc0;
    p = make_pkt(WREG, $urandom, rand192());
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    vc0 = valid_cycles;
    send_pkt(p, 1'b1, 1'b1, to);
    exp_err++;
    total++;
    if (to || pkt_err !== 1'b1 || err_cnt !== 16'(exp_err) || reg_map_valid !== 1'b0) begin
      bad++; $display("FAIL long_err got=pulse%b err%0d valid%b want=pulse1 err%0d valid0",
                      pkt_err, err_cnt, reg_map_valid, exp_err);
    end
    total++;
    if (valid_cycles != vc0 || reg_map_data !== exp_data) begin
      bad++; $display("FAIL long_image got=vc%0d %h want=vc%0d %h", valid_cycles, reg_map_data, vc0, exp_data);
    end
    step();
  endtask

  task automatic test_bad_cmd();
    bq_t p;
    bit to;
    int vc0;
    p = make_pkt(32'h0000_0000, $urandom, rand192());
    vc0 = valid_cycles;
    send_pkt(p, 1'b0, 1'b1, to);
    exp_err++;
    total++;
    if (to || pkt_err !== 1'b1 || err_cnt !== 16'(exp_err) || reg_map_valid !== 1'b0) begin
      bad++; $display("FAIL badcmd_err got=pulse%b err%0d valid%b want=pulse1 err%0d valid0",
                      pkt_err, err_cnt, reg_map_valid, exp_err);
    end
    step();
    total++;
    if (valid_cycles != vc0 || ok_cnt !== 16'(exp_ok)) begin
      bad++; $display("FAIL badcmd_noval got=vc%0d ok%0d want=vc%0d ok%0d", valid_cycles, ok_cnt, vc0, exp_ok);
    end
  endtask

  task automatic test_reset_mid();
    bq_t p;
    bit to;
    logic [191:0] d;
    p = make_pkt(WREG, $urandom, rand192());
    while (p.size() > 15) void'(p.pop_back());
    send_pkt(p, 1'b0, 1'b0, to);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ok = 0; exp_err = 0; exp_data = '0; exp_id = '0; exp_cmd = '0;
    d = rand192();
    p = make_pkt(WREG, 32'h1234_5678, d);
    reg_map_ready = 1'b1;
    send_pkt(p, 1'b1, 1'b1, to);
    total++;
    if (to || reg_map_valid !== 1'b1 || reg_map_data !== d || reg_map_pkt_id !== 32'h1234_5678) begin
      bad++; $display("FAIL rstmid_commit got=%b %h %h want=1 %h 12345678", reg_map_valid, reg_map_data, reg_map_pkt_id, d);
    end
    step();
    exp_ok = 1; exp_data = d; exp_id = 32'h1234_5678; exp_cmd = WREG;
    total++;
    if (ok_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL rstmid_counts got=ok%0d err%0d want=ok1 err0", ok_cnt, err_cnt);
    end
    reg_map_ready = 1'b0;
    send_pkt(make_pkt(WREG, $urandom, rand192()), 1'b0, 1'b1, to);
    rst = 1'b1;
    step();
    rst = 1'b0;
    reg_map_ready = 1'b1;
    exp_ok = 0; exp_err = 0; exp_data = '0; exp_id = '0; exp_cmd = '0;
    step();
    total++;
    if (reg_map_valid !== 1'b0 || ok_cnt !== 16'd0 || reg_map_data !== 192'd0) begin
      bad++; $display("FAIL rstcommit_drop got=valid%b ok%0d %h want=valid0 ok0 0", reg_map_valid, ok_cnt, reg_map_data);
    end
  endtask

  task automatic test_saturate();
    bq_t p;
    bit to;
    reg_map_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      p = make_pkt(WREG, $urandom, rand192());
      while (p.size() > 5 + n) void'(p.pop_back());
      send_pkt(p, 1'b0, 1'b1, to);
      exp_err++;
      step();
    end
    for (int n = 0; n < 4; n++) begin
      exp_data = rand192(); exp_id = $urandom; exp_cmd = WREG;
      send_pkt(make_pkt(WREG, exp_id, exp_data), 1'b0, 1'b1, to);
      step();
      exp_ok++;
    end
    total++;
    if (err_cnt2 !== 2'(sat3(exp_err)) || ok_cnt2 !== 2'(sat3(exp_ok))) begin
      bad++; $display("FAIL sat_twin got=ok%0d err%0d want=ok%0d err%0d", ok_cnt2, err_cnt2, sat3(exp_ok), sat3(exp_err));
    end
    total++;
    if (err_cnt !== 16'(exp_err) || ok_cnt !== 16'(exp_ok)) begin
      bad++; $display("FAIL sat_main got=ok%0d err%0d want=ok%0d err%0d", ok_cnt, err_cnt, exp_ok, exp_err);
    end
  endtask

  task automatic test_random();
    bq_t p;
    bit to;
    bit good;
    int kind;
    int hold;
    int sz;
    logic [31:0] cmd;
    logic [31:0] id;
    logic [191:0] d;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      cmd  = (kind < 6) ? WREG : $urandom;
      id   = $urandom;
      d    = rand192();
      p    = make_pkt(cmd, id, d);
      if (kind == 8) begin
        sz = $urandom_range(1, 31);
        while (p.size() > sz) void'(p.pop_back());
      end
      if (kind == 9) repeat ($urandom_range(1, 8)) p.push_back(8'($urandom));
      good = is_good(p);
      hold = $urandom_range(0, 3);
      reg_map_ready = (hold == 0);
      send_pkt(p, 1'b1, 1'b1, to);
      total++;
      if (to) begin bad++; $display("FAIL rand_timeout pkt=%0d got=timeout want=done", n); end
      if (good) begin
        total++;
        if (reg_map_valid !== 1'b1 || reg_map_data !== d || reg_map_pkt_id !== id || reg_map_cmd !== cmd) begin
          bad++; $display("FAIL rand_commit pkt=%0d got=%b %h %h want=1 %h %h", n, reg_map_valid, reg_map_data, reg_map_pkt_id, d, id);
        end
        repeat (hold) step();
        reg_map_ready = 1'b1;
        step();
        exp_ok++; exp_data = d; exp_id = id; exp_cmd = cmd;
        total++;
        if (reg_map_valid !== 1'b0 || ok_cnt !== 16'(exp_ok) || ok_cnt2 !== 2'(sat3(exp_ok))) begin
          bad++; $display("FAIL rand_ok pkt=%0d got=valid%b ok%0d/%0d want=valid0 ok%0d/%0d",
                          n, reg_map_valid, ok_cnt, ok_cnt2, exp_ok, sat3(exp_ok));
        end
      end else begin
        exp_err++;
        total++;
        if (pkt_err !== 1'b1 || reg_map_valid !== 1'b0 || err_cnt !== 16'(exp_err) ||
            err_cnt2 !== 2'(sat3(exp_err)) || reg_map_data !== exp_data) begin
          bad++; $display("FAIL rand_err pkt=%0d len=%0d got=pulse%b valid%b err%0d want=pulse1 valid0 err%0d",
                          n, p.size(), pkt_err, reg_map_valid, err_cnt, exp_err);
        end
        step();
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    rx_tdata = 8'h00;
    reg_map_ready = 1'b0;
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_short();
    test_long();
    test_bad_cmd();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
